// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: assembles one- or two-word instructions from fetch into decode bundles.
// Optional bubble counter output enabled by defining IF_ID_BUBBLE_CNT_EN.
module if_id_buffer #(
    parameter int unsigned PC_W      = 32,
    parameter logic [15:0] IMM_MASK  = 16'hE000,
    parameter logic [15:0] IMM_MATCH = 16'hC000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     word_in,
    input  logic            word_valid,
    input  logic [PC_W-1:0] pc_in,
    input  logic            stall,
    input  logic            flush,
    output logic            ready_out,
    output logic [15:0]     instr_out,
    output logic [15:0]     imm_out,
    output logic [PC_W-1:0] pc_out,
    output logic            has_imm,
`ifdef IF_ID_BUBBLE_CNT_EN
    output logic [15:0]     bubble_cnt,
`endif
    output logic            valid_out
);

    typedef enum logic [0:0] {StWaitOp, StWaitImm} state_e;

    state_e          state_q, state_d;
    logic [15:0]     instr_q, instr_d;
    logic [15:0]     imm_q, imm_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            has_imm_q, has_imm_d;
    logic            valid_q, valid_d;
    logic [15:0]     op_q, op_d;
    logic [PC_W-1:0] op_pc_q, op_pc_d;

    logic accept;
    logic two_word;

    assign ready_out = !stall;
    assign accept    = word_valid && ready_out && !flush;
    assign two_word  = (word_in & IMM_MASK) == IMM_MATCH;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWaitOp;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StWaitOp;
        end else if (stall) begin
            state_d = state_q;
        end else if (accept) begin
            unique case (state_q)
                StWaitOp:  state_d = two_word ? StWaitImm : StWaitOp;
                StWaitImm: state_d = StWaitOp;
                default:   state_d = StWaitOp;
            endcase
        end
    end

    // Output/datapath next values; outputs are registered, so these feed the _q flops
    always_comb begin
        instr_d   = instr_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        has_imm_d = has_imm_q;
        valid_d   = 1'b0;
        op_d      = op_q;
        op_pc_d   = op_pc_q;
        if (flush) begin
            has_imm_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (accept) begin
            unique case (state_q)
                StWaitOp: begin
                    if (two_word) begin
                        op_d    = word_in;
                        op_pc_d = pc_in;
                    end else begin
                        instr_d   = word_in;
                        pc_d      = pc_in;
                        imm_d     = '0;
                        has_imm_d = 1'b0;
                        valid_d   = 1'b1;
                    end
                end
                StWaitImm: begin
                    instr_d   = op_q;
                    pc_d      = op_pc_q;
                    imm_d     = word_in;
                    has_imm_d = 1'b1;
                    valid_d   = 1'b1;
                end
                default: begin
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            has_imm_q <= 1'b0;
            valid_q   <= 1'b0;
            op_q      <= '0;
            op_pc_q   <= '0;
        end else begin
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            has_imm_q <= has_imm_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            op_pc_q   <= op_pc_d;
        end
    end

    assign instr_out = instr_q;
    assign imm_out   = imm_q;
    assign pc_out    = pc_q;
    assign has_imm   = has_imm_q;
    assign valid_out = valid_q;

`ifdef IF_ID_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating count of cycles with no bundle presented; flush leaves it alone
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!valid_q && bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Pipeline buffer directly downstream of the fetch stage.
- Consumes the 16-bit instruction words fetch produces and assembles one- or two-word instructions (opcode word plus optional 16-bit immediate word) into a single bundle for decode.
- Supports stall (hold) and flush (squash), and inserts a bubble while waiting for an immediate word.

Parameters:
- PC_W, 32, width of the PC carried with each instruction.
- IMM_MASK, 16'hE000, bits of the first word compared to detect a two-word instruction.
- IMM_MATCH, 16'hC000, a first word is two-word when (word & IMM_MASK) == IMM_MATCH.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk rising edge.
- word_in  in  16  instruction word from fetch.
- word_valid  in  1  word_in carries a valid word this cycle.
- pc_in  in  PC_W  address of word_in.
- stall  in  1  hazard unit hold request.
- flush  in  1  squash request from branch/jump resolution.
- ready_out  out  1  buffer accepts word_in this cycle; equals !stall.
- instr_out  out  16  opcode word of the bundle.
- imm_out  out  16  immediate word; 0 for one-word instructions.
- pc_out  out  PC_W  PC of the opcode word.
- has_imm  out  1  bundle is a two-word instruction.
- valid_out  out  1  bundle valid for decode.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: instr_out=0, imm_out=0, pc_out=0, has_imm=0, valid_out=0, FSM=WAIT_OP.
- Priority: reset > flush > stall > normal.
- A word is accepted when word_valid && ready_out && !flush.
- FSM WAIT_OP, accepted word w:
  - If (w & IMM_MASK) != IMM_MATCH: next cycle instr_out=w, pc_out=pc_in, imm_out=0, has_imm=0, valid_out=1. Stay in WAIT_OP.
  - Otherwise: latch w and pc_in internally, valid_out=0 next cycle (bubble), go to WAIT_IMM.
- FSM WAIT_IMM, accepted word i: next cycle instr_out=latched opcode, pc_out=latched PC, imm_out=i, has_imm=1, valid_out=1. Go to WAIT_OP.
- No accepted word in either state: valid_out=0 next cycle, state unchanged.
- Latency: one-word bundle valid 1 cycle after acceptance. Two-word bundle valid 1 cycle after the immediate word is accepted.
- Stall:
  - All outputs and FSM state hold.
  - ready_out=0, so word_in is ignored.
  - A held valid bundle stays valid for every stalled cycle; no duplicate or lost bundle after release.
- Flush:
  - Next cycle valid_out=0, has_imm=0, FSM=WAIT_OP, and any partially assembled opcode is discarded.
  - A word presented in the flush cycle is dropped.
  - Data outputs may retain old values.
- Reset mid-assembly (in WAIT_IMM): returns to WAIT_OP and clears all outputs.
- Back-to-back one-word instructions: one bundle per cycle, no bubbles.
- A word matching IMM_MATCH that arrives in WAIT_IMM is treated as immediate data, not decoded.

Optional Feature:
- Macro: IF_ID_BUBBLE_CNT_EN.
- When defined:
  - Adds output bubble_cnt [15:0], reset to 0.
  - Increments on each cycle with valid_out==0 and reset==0.
  - Saturates at 16'hFFFF; flush does not clear it.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then words 16'h1234 @pc 0x20 and 16'h2345 @pc 0x21 on consecutive cycles -> valid_out=1 for two consecutive cycles with instr_out 1234/2345, pc_out 0x20/0x21, has_imm=0, imm_out=0.
- Word 16'hC801 @0x22 then 16'h00FF @0x23 -> one bubble cycle (valid_out=0), then instr_out=C801, imm_out=00FF, pc_out=0x22, has_imm=1, valid_out=1.
- Bundle 16'h1234 valid, stall held 3 cycles while fetch presents 16'h5555 -> outputs frozen at 1234 for 3 cycles, ready_out=0; 5555 is not captured unless presented again after release.
- Word 16'hC801 accepted, then flush together with 16'h00FF -> valid_out=0, state WAIT_OP; next word 16'h1111 yields a one-word bundle with instr_out=1111.
- Word 16'hC801 accepted, then reset asserted 1 cycle -> all outputs 0; next word 16'h00FF is decoded as a one-word instruction.
- With IF_ID_BUBBLE_CNT_EN: 5 idle cycles after reset -> bubble_cnt=5; force 70000 idle cycles -> bubble_cnt holds at 16'hFFFF.
